// File: rtl/multicycle_decoder_pkg.sv
// Shared types and encodings for the multicycle control decoder: FSM state
// enum, DP command codes, ALU operation encodings and datapath mux selects.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        TRAP   = 4'd10
    } state_t;

    // Instruction classes carried in Op
    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    // Data-processing command codes (Funct[4:1])
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    // ALU operation encodings driven on ALUControl
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_RA2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc selects
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_decoder_if.sv
// Instruction-register / datapath bundle of the multicycle control decoder.
// The master side is the IR + memory (drives instruction fields and the
// memory-ready handshake); the slave side is the decoder itself.
interface multicycle_decoder_if #(
    parameter int ALU_W   = 3,
    parameter int FUNCT_W = 6,
    parameter int STATE_W = 4
);
    logic [1:0]         Op;
    logic [FUNCT_W-1:0] Funct;
    logic [3:0]         Rd;
    logic               mem_ready;

    logic               IRWrite;
    logic               NextPC;
    logic               AdrSrc;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ResultSrc;
    logic               RegW;
    logic               MemW;
    logic               Branch;
    logic               PCS;
    logic [1:0]         ImmSrc;
    logic [1:0]         RegSrc;
    logic [ALU_W-1:0]   ALUControl;
    logic [1:0]         FlagW;
    logic               NoWrite;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        output Op, Funct, Rd, mem_ready,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, RegW,
               MemW, Branch, PCS, ImmSrc, RegSrc, ALUControl, FlagW,
               NoWrite, illegal, state
    );

    modport slave (
        input  Op, Funct, Rd, mem_ready,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, RegW,
               MemW, Branch, PCS, ImmSrc, RegSrc, ALUControl, FlagW,
               NoWrite, illegal, state
    );
endinterface

// File: rtl/multicycle_decoder_alu.sv
// Combinational ALU decoder. Maps the DP command in Funct to an ALU operation
// and flag-write mask; outputs are forced to 0 unless alu_active is high.
// cmd_illegal is never gated so the FSM can screen commands during DECODE.
// Funct layout is fixed at {I, cmd[3:0], S}; FUNCT_W must stay 6.
module alu_decoder
    import multicycle_pkg::*;
#(
    parameter int ALU_W   = 3,
    parameter int FUNCT_W = 6
) (
    input  logic [FUNCT_W-1:0] Funct,
    input  logic               alu_active,
    output logic [ALU_W-1:0]   ALUControl,
    output logic [1:0]         FlagW,
    output logic               NoWrite,
    output logic               cmd_illegal
);

    logic [3:0] cmd;
    logic       sbit;
    logic [2:0] alu_op;
    logic [1:0] flag_raw;
    logic       nowrite_raw;
    logic       unused_ibit;

    assign cmd         = Funct[4:1];
    assign sbit        = Funct[0];
    assign unused_ibit = Funct[FUNCT_W-1];

    // Decode the command, then gate everything except cmd_illegal by alu_active
    always_comb begin
        alu_op      = ALU_ADD;
        flag_raw    = 2'b00;
        nowrite_raw = 1'b0;
        cmd_illegal = 1'b0;
        case (cmd)
            CMD_ADD: begin alu_op = ALU_ADD; flag_raw = {sbit, sbit}; end
            CMD_SUB: begin alu_op = ALU_SUB; flag_raw = {sbit, sbit}; end
            CMD_AND: begin alu_op = ALU_AND; flag_raw = {sbit, 1'b0}; end
            CMD_ORR: begin alu_op = ALU_ORR; flag_raw = {sbit, 1'b0}; end
            CMD_MOV: begin alu_op = ALU_MOV; flag_raw = {sbit, 1'b0}; end
            CMD_CMP: begin
                alu_op      = ALU_SUB;
                flag_raw    = 2'b11;
                nowrite_raw = 1'b1;
            end
            default: cmd_illegal = 1'b1;
        endcase
        ALUControl = alu_active ? ALU_W'(alu_op) : '0;
        FlagW      = alu_active ? flag_raw : 2'b00;
        NoWrite    = alu_active & nowrite_raw;
    end

endmodule

// File: rtl/multicycle_decoder.sv
// Multicycle control unit for the ARM-subset core. A Moore FSM steps through
// fetch, decode, execute, memory and writeback, stalling on mem_ready in
// FETCH, MEMRD and MEMWR. Optional macro MULTICYCLE_DEC_TRAP_EN: illegal
// instructions lock the FSM in TRAP until reset; without it they retire as a
// NOP with a one-cycle illegal pulse in DECODE.
module multicycle_decoder
    import multicycle_pkg::*;
#(
    parameter int ALU_W   = 3,
    parameter int FUNCT_W = 6,
    parameter int STATE_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_decoder_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    logic             alu_active;
    logic             cmd_illegal;
    logic             cmd_is_cmp;
    logic             instr_illegal;
    logic [ALU_W-1:0] alu_control;
    logic [1:0]       flag_w;
    logic             no_write;

    logic       irwrite, nextpc, adrsrc, alusrca;
    logic [1:0] alusrcb, resultsrc, imm_src, reg_src;
    logic       regw, memw, branch, pcs, ill;

    alu_decoder #(
        .ALU_W   (ALU_W),
        .FUNCT_W (FUNCT_W)
    ) u_alu_decoder (
        .Funct       (bus.Funct),
        .alu_active  (alu_active),
        .ALUControl  (alu_control),
        .FlagW       (flag_w),
        .NoWrite     (no_write),
        .cmd_illegal (cmd_illegal)
    );

    // ALUWB decides RegW from the raw command, since NoWrite is gated there
    assign cmd_is_cmp    = (bus.Funct[4:1] == CMD_CMP);
    assign instr_illegal = (bus.Op == OP_UNDEF) | ((bus.Op == OP_DP) & cmd_illegal);

    // State register; reset forces FETCH immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state and Moore outputs; ImmSrc/RegSrc held at 0 until Op is valid
    always_comb begin
        state_d    = state_q;
        irwrite    = 1'b0;
        nextpc     = 1'b0;
        adrsrc     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RA2;
        resultsrc  = RES_ALUOUT;
        regw       = 1'b0;
        memw       = 1'b0;
        branch     = 1'b0;
        alu_active = 1'b0;
        ill        = 1'b0;
        imm_src    = bus.Op;
        reg_src    = {(bus.Op == OP_MEM) & ~bus.Funct[0], bus.Op == OP_BR};
        case (state_q)
            FETCH: begin
                imm_src   = 2'b00;
                reg_src   = 2'b00;
                alusrca   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALU;
                irwrite   = bus.mem_ready;
                nextpc    = bus.mem_ready;
                if (bus.mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alusrca   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALU;
                if (instr_illegal) begin
`ifdef MULTICYCLE_DEC_TRAP_EN
                    state_d = TRAP;
`else
                    ill     = 1'b1;
                    state_d = FETCH;
`endif
                end else begin
                    case (bus.Op)
                        OP_DP:   state_d = bus.Funct[FUNCT_W-1] ? EXECI : EXECR;
                        OP_MEM:  state_d = MEMADR;
                        OP_BR:   state_d = BRANCH;
                        default: state_d = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                alusrcb = SRCB_IMM;
                state_d = bus.Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adrsrc = 1'b1;
                if (bus.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                resultsrc = RES_RDATA;
                regw      = 1'b1;
                state_d   = FETCH;
            end
            MEMWR: begin
                adrsrc = 1'b1;
                memw   = 1'b1;
                if (bus.mem_ready) state_d = FETCH;
            end
            EXECR: begin
                alu_active = 1'b1;
                state_d    = ALUWB;
            end
            EXECI: begin
                alusrcb    = SRCB_IMM;
                alu_active = 1'b1;
                state_d    = ALUWB;
            end
            ALUWB: begin
                regw    = ~cmd_is_cmp;
                state_d = FETCH;
            end
            BRANCH: begin
                alusrcb   = SRCB_IMM;
                resultsrc = RES_ALU;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            TRAP: begin
                imm_src = 2'b00;
                reg_src = 2'b00;
`ifdef MULTICYCLE_DEC_TRAP_EN
                ill     = 1'b1;
                state_d = TRAP;
`else
                state_d = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase
        pcs = branch | (regw & (bus.Rd == 4'hF));
    end

    assign bus.IRWrite    = irwrite;
    assign bus.NextPC     = nextpc;
    assign bus.AdrSrc     = adrsrc;
    assign bus.ALUSrcA    = alusrca;
    assign bus.ALUSrcB    = alusrcb;
    assign bus.ResultSrc  = resultsrc;
    assign bus.RegW       = regw;
    assign bus.MemW       = memw;
    assign bus.Branch     = branch;
    assign bus.PCS        = pcs;
    assign bus.ImmSrc     = imm_src;
    assign bus.RegSrc     = reg_src;
    assign bus.ALUControl = alu_control;
    assign bus.FlagW      = flag_w;
    assign bus.NoWrite    = no_write;
    assign bus.illegal    = ill;
    assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_decoder.sv
// Self-checking bench for multicycle_decoder: directed scenarios plus random
// instruction streams checked against a per-instruction cycle-plan model.
module tb_multicycle_decoder;
    import multicycle_pkg::*;

    localparam int ALU_W   = 3;
    localparam int FUNCT_W = 6;
    localparam int STATE_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    always #5 clk = ~clk;

    multicycle_decoder_if #(.ALU_W(ALU_W), .FUNCT_W(FUNCT_W), .STATE_W(STATE_W)) bus ();

    multicycle_decoder #(.ALU_W(ALU_W), .FUNCT_W(FUNCT_W), .STATE_W(STATE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       irw, npc, adr, srca;
        logic [1:0] srcb, res;
        logic       regw, memw, br, pcs;
        logic [1:0] imm, regsrc;
        logic [2:0] aluc;
        logic [1:0] flagw;
        logic       nowr, ill;
    } outs_t;

    typedef struct {
        state_t st;
        logic   mr;
    } step_t;

    step_t plan[$];

    function automatic outs_t sample_outs();
        outs_t o;
        o.irw = bus.IRWrite;   o.npc = bus.NextPC;   o.adr = bus.AdrSrc;
        o.srca = bus.ALUSrcA;  o.srcb = bus.ALUSrcB; o.res = bus.ResultSrc;
        o.regw = bus.RegW;     o.memw = bus.MemW;    o.br = bus.Branch;
        o.pcs = bus.PCS;       o.imm = bus.ImmSrc;   o.regsrc = bus.RegSrc;
        o.aluc = bus.ALUControl; o.flagw = bus.FlagW; o.nowr = bus.NoWrite;
        o.ill = bus.illegal;
        return o;
    endfunction

    function automatic logic model_illegal(input logic [1:0] op, input logic [5:0] f);
        logic [3:0] c;
        c = f[4:1];
        if (op == 2'b11) return 1'b1;
        if (op != 2'b00) return 1'b0;
        return !(c == 4'b0100 || c == 4'b0010 || c == 4'b0000 ||
                 c == 4'b1100 || c == 4'b1101 || c == 4'b1010);
    endfunction

    // Output table of each step, written straight from the step descriptions
    function automatic outs_t model_outs(input state_t st, input logic [1:0] op,
                                         input logic [5:0] f, input logic [3:0] rd,
                                         input logic mr);
        outs_t      o;
        logic [3:0] c;
        logic       s;
        o = '0;
        c = f[4:1];
        s = f[0];
        if (st != FETCH && st != TRAP) begin
            o.imm    = op;
            o.regsrc = {op == 2'b01 && !f[0], op == 2'b10};
        end
        case (st)
            FETCH:  begin o.srca = 1; o.srcb = 2'b10; o.res = 2'b10; o.irw = mr; o.npc = mr; end
            DECODE: begin
                o.srca = 1; o.srcb = 2'b10; o.res = 2'b10;
`ifndef MULTICYCLE_DEC_TRAP_EN
                o.ill = model_illegal(op, f);
`endif
            end
            MEMADR: o.srcb = 2'b01;
            MEMRD:  o.adr = 1;
            MEMWB:  begin o.res = 2'b01; o.regw = 1; end
            MEMWR:  begin o.adr = 1; o.memw = 1; end
            EXECR, EXECI: begin
                o.srcb = (st == EXECI) ? 2'b01 : 2'b00;
                case (c)
                    4'b0100: begin o.aluc = 3'd0; o.flagw = {s, s}; end
                    4'b0010: begin o.aluc = 3'd1; o.flagw = {s, s}; end
                    4'b0000: begin o.aluc = 3'd2; o.flagw = {s, 1'b0}; end
                    4'b1100: begin o.aluc = 3'd3; o.flagw = {s, 1'b0}; end
                    4'b1101: begin o.aluc = 3'd4; o.flagw = {s, 1'b0}; end
                    4'b1010: begin o.aluc = 3'd1; o.flagw = 2'b11; o.nowr = 1; end
                    default: ;
                endcase
            end
            ALUWB:  o.regw = (c != 4'b1010);
            BRANCH: begin o.srcb = 2'b01; o.res = 2'b10; o.br = 1; end
            TRAP:   o.ill = 1;
            default: ;
        endcase
        o.pcs = o.br | (o.regw & (rd == 4'hF));
        return o;
    endfunction

    function automatic void add_step(input state_t st, input logic mr);
        step_t p;
        p.st = st;
        p.mr = mr;
        plan.push_back(p);
    endfunction

    // Cycle plan of one instruction: fetch waits, decode, then the class path
    function automatic void build_plan(input logic [1:0] op, input logic [5:0] f,
                                       input int wf, input int wm);
        plan.delete();
        for (int i = 0; i < wf; i++) add_step(FETCH, 1'b0);
        add_step(FETCH, 1'b1);
        add_step(DECODE, 1'($urandom_range(0, 1)));
        if (model_illegal(op, f)) begin
`ifdef MULTICYCLE_DEC_TRAP_EN
            add_step(TRAP, 1'($urandom_range(0, 1)));
`endif
        end else if (op == 2'b00) begin
            add_step(f[5] ? EXECI : EXECR, 1'($urandom_range(0, 1)));
            add_step(ALUWB, 1'($urandom_range(0, 1)));
        end else if (op == 2'b01) begin
            add_step(MEMADR, 1'($urandom_range(0, 1)));
            for (int i = 0; i < wm; i++) add_step(f[0] ? MEMRD : MEMWR, 1'b0);
            add_step(f[0] ? MEMRD : MEMWR, 1'b1);
            if (f[0]) add_step(MEMWB, 1'($urandom_range(0, 1)));
        end else begin
            add_step(BRANCH, 1'($urandom_range(0, 1)));
        end
    endfunction

    task automatic drive_cycle(input logic mr, output logic [3:0] obs_st, output outs_t obs_o);
        bus.mem_ready = mr;
        @(negedge clk);
        obs_st = bus.state;
        obs_o  = sample_outs();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
        bus.Op    = op;
        bus.Funct = f;
        bus.Rd    = rd;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        outs_t o;
        outs_t e;
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        set_instr(2'b11, 6'($urandom), 4'hF);
        #12;
        o = sample_outs();
        e = model_outs(FETCH, 2'b11, bus.Funct, 4'hF, 1'b0);
        n_compared++;
        if (bus.state !== 4'(FETCH)) begin
            n_mismatched++;
            $display("[TB] FAIL reset_state got %0d expected %0d", bus.state, FETCH);
        end
        n_compared++;
        if (o !== e) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs got %h expected %h", o, e);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_dp_add();
        state_t     seq[4] = '{FETCH, DECODE, EXECR, ALUWB};
        logic [3:0] st;
        outs_t      o;
        set_instr(2'b00, 6'b0_0100_1, 4'd3);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, st, o);
            n_compared++;
            if (st !== 4'(seq[i])) begin
                n_mismatched++;
                $display("[TB] FAIL add_state cycle %0d got %0d expected %0d", i + 1, st, seq[i]);
            end
            if (i == 2) begin
                n_compared++;
                if (o.aluc !== 3'b000 || o.flagw !== 2'b11) begin
                    n_mismatched++;
                    $display("[TB] FAIL add_alu got aluc=%b flagw=%b expected 000/11", o.aluc, o.flagw);
                end
            end
            if (i == 3) begin
                n_compared++;
                if (o.regw !== 1'b1 || o.pcs !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL add_wb got regw=%b pcs=%b expected 1/0", o.regw, o.pcs);
                end
            end
        end
    endtask

    task automatic test_ldr_wait();
        logic       mrs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] st;
        outs_t      o;
        int         rd_cycles = 0;
        set_instr(2'b01, 6'b0_0100_1, 4'd5);
        for (int i = 0; i < 7; i++) begin
            drive_cycle(mrs[i], st, o);
            if (st == 4'(MEMRD)) rd_cycles++;
        end
        n_compared++;
        if (rd_cycles !== 3) begin
            n_mismatched++;
            $display("[TB] FAIL ldr_memrd_len got %0d expected 3", rd_cycles);
        end
        n_compared++;
        if (st !== 4'(MEMWB) || o.res !== 2'b01 || o.regw !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL ldr_wb got state=%0d res=%b regw=%b expected %0d/01/1", st, o.res, o.regw, MEMWB);
        end
    endtask

    task automatic test_cmp_imm();
        logic [3:0] st;
        outs_t      o;
        set_instr(2'b00, 6'b1_1010_1, 4'd2);
        drive_cycle(1'b1, st, o);
        drive_cycle(1'b1, st, o);
        drive_cycle(1'b1, st, o);
        n_compared++;
        if (st !== 4'(EXECI) || o.aluc !== 3'b001 || o.flagw !== 2'b11 || o.nowr !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL cmp_exec got state=%0d aluc=%b flagw=%b nowr=%b", st, o.aluc, o.flagw, o.nowr);
        end
        drive_cycle(1'b1, st, o);
        n_compared++;
        if (st !== 4'(ALUWB) || o.regw !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL cmp_wb got state=%0d regw=%b expected %0d/0", st, o.regw, ALUWB);
        end
    endtask

    task automatic test_pcs();
        logic [3:0] st;
        outs_t      o;
        set_instr(2'b00, 6'b0_0100_0, 4'hF);
        for (int i = 1; i <= 4; i++) begin
            drive_cycle(1'b1, st, o);
            n_compared++;
            if (o.pcs !== (i == 4)) begin
                n_mismatched++;
                $display("[TB] FAIL pcs_add cycle %0d got %b expected %b", i, o.pcs, (i == 4));
            end
        end
        set_instr(2'b10, 6'b0_0000_0, 4'd0);
        for (int i = 1; i <= 3; i++) begin
            drive_cycle(1'b1, st, o);
            n_compared++;
            if (o.pcs !== (i == 3) || o.br !== (i == 3)) begin
                n_mismatched++;
                $display("[TB] FAIL pcs_branch cycle %0d got pcs=%b br=%b", i, o.pcs, o.br);
            end
        end
        n_compared++;
        if (st !== 4'(BRANCH)) begin
            n_mismatched++;
            $display("[TB] FAIL branch_state got %0d expected %0d", st, BRANCH);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] st;
        outs_t      o;
        set_instr(2'b11, 6'b0_0100_1, 4'd1);
        drive_cycle(1'b1, st, o);
        drive_cycle(1'b1, st, o);
`ifdef MULTICYCLE_DEC_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), st, o);
            n_compared++;
            if (st !== 4'(TRAP) || o.ill !== 1'b1 || o.regw !== 1'b0 || o.memw !== 1'b0 || o.irw !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL trap_hold got state=%0d ill=%b regw=%b memw=%b irw=%b", st, o.ill, o.regw, o.memw, o.irw);
            end
        end
        do_reset();
`else
        n_compared++;
        if (st !== 4'(DECODE) || o.ill !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL illegal_pulse got state=%0d ill=%b expected %0d/1", st, o.ill, DECODE);
        end
        set_instr(2'b00, 6'b0_0111_0, 4'd1);
        drive_cycle(1'b0, st, o);
        n_compared++;
        if (st !== 4'(FETCH) || o.ill !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL illegal_nop got state=%0d ill=%b expected %0d/0", st, o.ill, FETCH);
        end
        drive_cycle(1'b1, st, o);
        drive_cycle(1'b1, st, o);
        n_compared++;
        if (st !== 4'(DECODE) || o.ill !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL illegal_cmd got state=%0d ill=%b expected %0d/1", st, o.ill, DECODE);
        end
`endif
    endtask

    task automatic test_reset_mid_memwr();
        logic [3:0] st;
        outs_t      o;
        set_instr(2'b01, 6'b0_0100_0, 4'd7);
        drive_cycle(1'b1, st, o);
        drive_cycle(1'b1, st, o);
        drive_cycle(1'b1, st, o);
        drive_cycle(1'b0, st, o);
        n_compared++;
        if (st !== 4'(MEMWR) || o.memw !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL str_memwr got state=%0d memw=%b expected %0d/1", st, o.memw, MEMWR);
        end
        bus.mem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_compared++;
        if (bus.state !== 4'(FETCH) || bus.MemW !== 1'b0 || bus.RegW !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset got state=%0d memw=%b regw=%b", bus.state, bus.MemW, bus.RegW);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_compared++;
        if (bus.state !== 4'(FETCH) || bus.ALUSrcB !== 2'b10) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset got state=%0d srcb=%b expected %0d/10", bus.state, bus.ALUSrcB, FETCH);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [3:0] st;
        outs_t      o;
        outs_t      e;
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] rd;
        logic [3:0] legal_cmds[6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101, 4'b1010};
        for (int n = 0; n < 60; n++) begin
            do begin
                op = 2'($urandom_range(0, 3));
                f  = 6'($urandom);
                if (op == 2'b00 && $urandom_range(0, 3) != 0)
                    f[4:1] = legal_cmds[$urandom_range(0, 5)];
`ifdef MULTICYCLE_DEC_TRAP_EN
            end while (model_illegal(op, f));
`else
            end while (1'b0);
`endif
            rd = 4'($urandom);
            set_instr(op, f, rd);
            build_plan(op, f, $urandom_range(0, 2), $urandom_range(0, 3));
            foreach (plan[i]) begin
                drive_cycle(plan[i].mr, st, o);
                e = model_outs(plan[i].st, op, f, rd, plan[i].mr);
                n_compared++;
                if (st !== 4'(plan[i].st)) begin
                    n_mismatched++;
                    $display("[TB] FAIL rand_state instr %0d step %0d got %0d expected %0d", n, i, st, plan[i].st);
                end
                n_compared++;
                if (o !== e) begin
                    n_mismatched++;
                    $display("[TB] FAIL rand_outs instr %0d step %0d got %h expected %h", n, i, o, e);
                end
            end
        end
    endtask

    initial begin
        $display("[TB] multicycle_decoder bench start");
        test_reset();
        test_dp_add();
        test_ldr_wait();
        test_cmp_imm();
        test_pcs();
        test_illegal();
        test_reset_mid_memwr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_decoder.md
Name: multicycle_decoder

Overview:
- Parametrised successor to the single-cycle control decoder.
- Multicycle control unit for the ARM-subset core: a Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles.
- Decodes an extended DP command set, stalls on a memory-ready handshake, and drives datapath mux selects, write enables and ALU control.
- Sits between the instruction register and the shared ALU/memory datapath.

Parameters:
- ALU_W, 3, width of ALUControl (minimum 3).
- FUNCT_W, 6, width of Funct: {I, cmd[3:0], S}. Fixed encoding; a value other than 6 is illegal.
- STATE_W, 4, width of the state debug output.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high; forces FETCH
- Op  in  2  instruction class from IR; valid from DECODE onward
- Funct  in  FUNCT_W  {I, cmd, S}; for memory ops Funct[0] = L (load)
- Rd  in  4  destination register
- mem_ready  in  1  memory completes access this cycle
- IRWrite  out  1  load instruction register
- NextPC  out  1  PC update with PC+4
- AdrSrc  out  1  0 = PC, 1 = ALU result as memory address
- ALUSrcA  out  1  0 = RA1 data, 1 = PC
- ALUSrcB  out  2  00 = RA2, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALU result direct
- RegW  out  1  register-file write enable
- MemW  out  1  memory write enable
- Branch  out  1  branch step (condition gating is external)
- PCS  out  1  Branch | (RegW & Rd == 4'hF)
- ImmSrc  out  2  = Op
- RegSrc  out  2  {Op==01 & !L, Op==10}
- ALUControl  out  ALU_W  ALU operation select
- FlagW  out  2  [1] = NZ update, [0] = CV update
- NoWrite  out  1  CMP: suppress writeback
- illegal  out  1  undefined instruction seen (see Optional Feature)
- state  out  STATE_W  current FSM state (debug)

Behaviour:
- Outputs are Moore outputs of the state. ALUControl, FlagW and NoWrite are combinational from Funct and are gated to 0 outside EXECR and EXECI.
- Reset value: state = FETCH. Every output is 0 except the FETCH constant selects: ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10.
- FETCH:
  - AdrSrc = 0.
  - IRWrite = NextPC = mem_ready.
  - Stay in FETCH while !mem_ready; go to DECODE on mem_ready.
- DECODE: ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10. Next state by Op:
  - 01 -> MEMADR
  - 00 & I -> EXECI
  - 00 & !I -> EXECR
  - 10 -> BRANCH
  - 11 -> ILLEGAL handling
- MEMADR: ALUSrcA = 0, ALUSrcB = 01. Go to MEMRD if L, else MEMWR.
- MEMRD: AdrSrc = 1. Wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc = 01, RegW = 1, then FETCH. One cycle.
- MEMWR: AdrSrc = 1, MemW = 1. MemW is held until the cycle with mem_ready, then FETCH.
- EXECR: ALUSrcA = 0, ALUSrcB = 00, ALU decode active, then ALUWB.
- EXECI: ALUSrcA = 0, ALUSrcB = 01, ALU decode active, then ALUWB.
- ALUWB: ResultSrc = 00, RegW = !NoWrite (NoWrite re-evaluated from Funct), then FETCH.
- BRANCH: ALUSrcA = 0, ALUSrcB = 01, ResultSrc = 10, Branch = 1, then FETCH.
- ALU decode by cmd:
  - 0100 ADD -> 000
  - 0010 SUB -> 001
  - 0000 AND -> 010
  - 1100 ORR -> 011
  - 1101 MOV -> 100
  - 1010 CMP -> 001, with NoWrite = 1 and FlagW = 11
  - Any other cmd is illegal.
- Flag writes: FlagW[1] = S. FlagW[0] = S & (ADD | SUB).
- Latency: DP = 4 cycles, LDR = 5, STR = 4, B = 3, each plus memory wait cycles.
- PCS asserts only in writeback or BRANCH states.
- Reset asserted mid-operation: state goes to FETCH asynchronously, and MemW/RegW drop in the same cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Optional Feature:
- Macro: MULTICYCLE_DEC_TRAP_EN.
- Defined:
  - Illegal Op or cmd in DECODE goes to TRAP.
  - In TRAP, illegal = 1 and all enables are 0.
  - TRAP is left only by reset.
- Undefined:
  - Illegal instructions go from DECODE directly to FETCH as a NOP.
  - illegal is a 1-cycle pulse in that DECODE cycle.

Decomposition:
- Package multicycle_pkg holds:
  - state_t enum
  - cmd codes: CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_MOV, CMD_CMP
  - ALU_* encodings
  - ALUSrcB and ResultSrc select constants
- Sub-module alu_decoder is combinational: Funct and alu_active in; ALUControl, FlagW, NoWrite and cmd_illegal out.
- The FSM lives in the top module.

Test Plan:
- Reset mid-MEMWR with MemW = 1 -> MemW = 0 and state = FETCH in the same cycle; ALUSrcB = 10 after release.
- Op = 00, Funct = 6'b0_0100_1, Rd = 3, mem_ready = 1 -> states FETCH, DECODE, EXECR, ALUWB; ALUControl = 000; FlagW = 11 (S set, arithmetic); RegW = 1 in cycle 4.
- LDR (Op = 01, L = 1) with mem_ready low for 2 cycles in MEMRD -> MEMRD lasts 3 cycles, then MEMWB with ResultSrc = 01 and RegW = 1.
- CMP immediate (Funct = 6'b1_1010_1) -> ALUControl = 001, FlagW = 11, RegW = 0 in ALUWB.
- ADD with Rd = 15 -> PCS = 1 in ALUWB only. Branch -> Branch = 1 and PCS = 1 in BRANCH.
- Op = 11:
  - With MULTICYCLE_DEC_TRAP_EN defined: illegal stays 1 until reset.
  - Without it: one-cycle pulse, then FETCH.
